// File: rtl/regfile_scoreboard_if.sv
// Bundle of signals between decode/writeback (master) and the
// register file with scoreboard (slave).
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // writeback port
  logic              write_enable;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  // operand read ports
  logic [ADDR_W-1:0] read_addr1;
  logic [ADDR_W-1:0] read_addr2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  // destination reservation from decode
  logic              reserve_en;
  logic [ADDR_W-1:0] reserve_addr;
  // hazard status
  logic              busy1;
  logic              busy2;
  logic              stall;
  logic [ADDR_W:0]   pending_count;

  modport master (
    output write_enable, write_addr, write_data,
    output read_addr1, read_addr2,
    output reserve_en, reserve_addr,
    input  read_data1, read_data2,
    input  busy1, busy2, stall, pending_count
  );

  modport slave (
    input  write_enable, write_addr, write_data,
    input  read_addr1, read_addr2,
    input  reserve_en, reserve_addr,
    output read_data1, read_data2,
    output busy1, busy2, stall, pending_count
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Two-read / one-write register file with a per-register pending-write
// scoreboard for RAW/WAW hazard detection in the ID stage.
// Register 0 is hardwired to zero and is never busy.
// Optional feature: define REGFILE_BYPASS_EN to forward the writeback
// value (and clear the busy indication) to a read port in the same cycle.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_scoreboard_if.slave  bus
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;
  logic [NUM_REGS-1:0] set_hit;
  logic [NUM_REGS-1:0] clr_hit;
  logic [ADDR_W:0]     count_reg;
  logic [ADDR_W:0]     count_next;
  logic                wr_hit;
  logic                rsv_hit;
  logic                count_inc;
  logic                count_dec;
  logic                byp1;
  logic                byp2;
  logic [DATA_W-1:0]   stored1;
  logic [DATA_W-1:0]   stored2;
  logic                busy1_int;
  logic                busy2_int;

  // Writes and reservations to register 0 are discarded up front.
  assign wr_hit  = bus.write_enable && (bus.write_addr != '0);
  assign rsv_hit = bus.reserve_en && (bus.reserve_addr != '0);

  // Per-register set/clear decode; a reservation beats a write to the
  // same register, so the register stays busy for the newer producer.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
        assign set_hit[gi] = 1'b0;
        assign clr_hit[gi] = 1'b0;
      end else begin : g_reg
        assign set_hit[gi] = rsv_hit && (bus.reserve_addr == ADDR_W'(gi));
        assign clr_hit[gi] = wr_hit && (bus.write_addr == ADDR_W'(gi)) && !set_hit[gi];
      end
    end
  endgenerate

  // Next scoreboard state and population change; count only moves when a
  // bit actually flips, so re-reserving a busy register leaves it alone.
  always_comb begin
    busy_next  = (busy_reg | set_hit) & ~clr_hit;
    count_inc  = |(set_hit & ~busy_reg);
    count_dec  = |(clr_hit & busy_reg);
    count_next = count_reg + {{ADDR_W{1'b0}}, count_inc} - {{ADDR_W{1'b0}}, count_dec};
  end

  // Scoreboard and pending counter; reset dominates everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg  <= '0;
      count_reg <= '0;
    end else begin
      busy_reg  <= busy_next;
      count_reg <= count_next;
    end
  end

  // Register storage; entry 0 is never written so it holds its reset zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wr_hit) begin
      regs_reg[bus.write_addr] <= bus.write_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign byp1 = wr_hit && (bus.write_addr == bus.read_addr1);
  assign byp2 = wr_hit && (bus.write_addr == bus.read_addr2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // Combinational operand read with optional same-cycle forwarding.
  always_comb begin
    stored1   = (bus.read_addr1 == '0) ? '0 : regs_reg[bus.read_addr1];
    stored2   = (bus.read_addr2 == '0) ? '0 : regs_reg[bus.read_addr2];
    busy1_int = (bus.read_addr1 != '0) && busy_reg[bus.read_addr1] && !byp1;
    busy2_int = (bus.read_addr2 != '0) && busy_reg[bus.read_addr2] && !byp2;
  end

  assign bus.read_data1    = byp1 ? bus.write_data : stored1;
  assign bus.read_data2    = byp2 ? bus.write_data : stored2;
  assign bus.busy1         = busy1_int;
  assign bus.busy2         = busy2_int;
  // A reservation of an already-busy register is a WAW hazard.
  assign bus.stall         = busy1_int | busy2_int |
                             (bus.reserve_en & busy_reg[bus.reserve_addr]);
  assign bus.pending_count = count_reg;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard testbench for regfile_scoreboard: the stimulus process pushes
// the expected outputs for the current cycle, a monitor pops and compares
// them on the falling edge.
module tb_regfile_scoreboard;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        b1;
    logic        b2;
    logic        st;
    logic [5:0]  cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  exp_t exp_q[$];

  regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expectation per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tests_run++;
      if (bus.read_data1 !== e.rd1 || bus.read_data2 !== e.rd2 ||
          bus.busy1 !== e.b1 || bus.busy2 !== e.b2 ||
          bus.stall !== e.st || bus.pending_count !== e.cnt) begin
        tests_failed++;
        $display("FAIL %s: got rd1=%h rd2=%h b1=%b b2=%b stall=%b cnt=%0d expected rd1=%h rd2=%h b1=%b b2=%b stall=%b cnt=%0d",
                 e.name, bus.read_data1, bus.read_data2, bus.busy1, bus.busy2,
                 bus.stall, bus.pending_count, e.rd1, e.rd2, e.b1, e.b2, e.st, e.cnt);
      end else begin
        $display("[TB] ok %s: rd1=%h rd2=%h b1=%b b2=%b stall=%b cnt=%0d",
                 e.name, bus.read_data1, bus.read_data2, bus.busy1, bus.busy2,
                 bus.stall, bus.pending_count);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] radr,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    bus.write_enable = we;
    bus.write_addr   = wa;
    bus.write_data   = wd;
    bus.reserve_en   = re;
    bus.reserve_addr = radr;
    bus.read_addr1   = ra1;
    bus.read_addr2   = ra2;
  endtask

  task automatic expect_now(input string name, input logic [31:0] rd1, input logic [31:0] rd2,
                            input logic b1, input logic b2, input logic st,
                            input logic [5:0] cnt);
    exp_t e;
    e.name = name;
    e.rd1  = rd1;
    e.rd2  = rd2;
    e.b1   = b1;
    e.b2   = b2;
    e.st   = st;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  initial begin
    int budget;
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd2);
    @(posedge clk);
    step();
    expect_now("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0);

    // basic writes then read back
    step(); rst = 1'b0;
    drive(1'b1, 5'd1, 32'hAABBCCDD, 1'b0, 5'd0, 5'd3, 5'd4);
    step(); drive(1'b1, 5'd2, 32'h11223344, 1'b0, 5'd0, 5'd3, 5'd4);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd2);
    expect_now("read_r1_r2", 32'hAABBCCDD, 32'h11223344, 1'b0, 1'b0, 1'b0, 6'd0);

    // register 0 inert
    step(); drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd2);
    expect_now("r0_write_reserve", 32'h0, 32'h11223344, 1'b0, 1'b0, 1'b0, 6'd0);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    expect_now("r0_after", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0);

    // RAW stall on r5
    step(); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd1, 5'd2);
    expect_now("reserve_r5", 32'hAABBCCDD, 32'h11223344, 1'b0, 1'b0, 1'b0, 6'd0);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
    expect_now("raw_stall_r5", 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 6'd1);
    step(); drive(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 5'd5, 5'd0);
    expect_now("write_r5_same_cycle", BYP ? 32'h12345678 : 32'h0, 32'h0,
               !BYP, 1'b0, !BYP, 6'd1);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
    expect_now("r5_released", 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0);

    // reserve and write the same register r7
    step(); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd0);
    expect_now("reserve_r7", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0);
    step(); drive(1'b1, 5'd7, 32'h77770007, 1'b1, 5'd7, 5'd7, 5'd0);
    expect_now("rsv_wr_r7_same", BYP ? 32'h77770007 : 32'h0, 32'h0,
               !BYP, 1'b0, 1'b1, 6'd1);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
    expect_now("r7_still_busy", 32'h77770007, 32'h0, 1'b1, 1'b0, 1'b1, 6'd1);

    // reserve r8 while writing r7
    step(); drive(1'b1, 5'd7, 32'h7777AAAA, 1'b1, 5'd8, 5'd7, 5'd8);
    expect_now("rsv_r8_wr_r7", BYP ? 32'h7777AAAA : 32'h77770007, 32'h0,
               !BYP, 1'b0, !BYP, 6'd1);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd8);
    expect_now("r8_busy_r7_clear", 32'h7777AAAA, 32'h0, 1'b0, 1'b1, 1'b1, 6'd1);
    step(); drive(1'b1, 5'd8, 32'h00000088, 1'b0, 5'd0, 5'd7, 5'd8);
    expect_now("write_r8_port2", 32'h7777AAAA, BYP ? 32'h00000088 : 32'h0,
               1'b0, !BYP, !BYP, 6'd1);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd8);
    expect_now("r8_released", 32'h7777AAAA, 32'h00000088, 1'b0, 1'b0, 1'b0, 6'd0);

    // WAW on r9
    step(); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd0);
    expect_now("reserve_r9", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd0);
    expect_now("waw_r9_stall", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 6'd1);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
    expect_now("waw_count_held", 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 6'd1);

    // write r9 and reserve r3 together: net zero on the count
    step(); drive(1'b1, 5'd9, 32'h00000099, 1'b1, 5'd3, 5'd9, 5'd3);
    expect_now("wr_r9_rsv_r3", BYP ? 32'h00000099 : 32'h0, 32'h0,
               !BYP, 1'b0, !BYP, 6'd1);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd3);
    expect_now("r3_busy_net0", 32'h00000099, 32'h0, 1'b0, 1'b1, 1'b1, 6'd1);

    // reset mid-operation with concurrent write and reserve
    step(); rst = 1'b1;
    drive(1'b1, 5'd3, 32'h0000DEAD, 1'b1, 5'd4, 5'd3, 5'd4);
    step(); rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
    expect_now("mid_reset_r3_r4", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd9);
    expect_now("mid_reset_r1_r9", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0);
    step(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd5);
    expect_now("mid_reset_r7_r5", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0);

    // let the monitor drain, bounded
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      step();
      budget++;
    end
    if (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
